// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned calc_ch_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: wrap counter, shadow divisor with deferred apply, one-shot done and square wave.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_TERM = 999
) (
    input  logic             origin_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_term,
    input  logic             cfg_mode,
    output logic             tick,
    output logic             sq,
    output logic             pending,
    output logic             done
);

    localparam logic [CNT_W-1:0] TermRst = CNT_W'(DEFAULT_TERM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] term_q;
    logic [CNT_W-1:0] term_s_q;
    logic             mode_q;
    logic             mode_s_q;
    logic             pending_q;
    logic             done_q;
    logic             sq_q;
    logic             apply;

    assign tick  = en & ~done_q & ~rst & (cnt_q == term_q);
    // Shadow may only swap in at a wrap or while the counter is not moving.
    assign apply = pending_q & (tick | ~en | done_q);

    always_ff @(posedge origin_clk) begin
        if (rst) begin
            cnt_q     <= '0;
            term_q    <= TermRst;
            term_s_q  <= TermRst;
            mode_q    <= MODE_PERIODIC;
            mode_s_q  <= MODE_PERIODIC;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            if (cfg_we) begin
                term_s_q <= cfg_term;
                mode_s_q <= cfg_mode;
            end
            if (restart) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                sq_q   <= 1'b0;
                if (pending_q) begin
                    term_q <= term_s_q;
                    mode_q <= mode_s_q;
                end
                // A write landing with the restart stays pending for the next opportunity.
                pending_q <= cfg_we;
            end else if (apply) begin
                term_q    <= term_s_q;
                mode_q    <= mode_s_q;
                cnt_q     <= '0;
                done_q    <= 1'b0;
                pending_q <= cfg_we;
                if (tick) begin
                    sq_q <= ~sq_q;
                end
            end else begin
                pending_q <= pending_q | cfg_we;
                if (en && !done_q) begin
                    if (cnt_q >= term_q) begin
                        cnt_q <= '0;
                        sq_q  <= ~sq_q;
                        if (mode_q == MODE_ONESHOT) begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign sq      = sq_q;
    assign pending = pending_q;
    assign done    = done_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator; ticks are clock enables, never clocks.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_TERM = 999,
    parameter int unsigned CH_W         = calc_ch_w(N_CH)
) (
    input  logic             origin_clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_term,
    input  logic             cfg_mode,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  done
);

    logic            ch_valid;
    logic [N_CH-1:0] cfg_we;

    assign ch_valid = (32'(cfg_ch) < N_CH);

    // Out-of-range channels always accept so a stray request never wedges the port.
    always_comb begin
        cfg_ready = 1'b1;
        if (ch_valid) begin
            cfg_ready = ~pending[cfg_ch];
        end
    end

    always_comb begin
        cfg_we = '0;
        if (cfg_valid && cfg_ready && ch_valid) begin
            cfg_we[cfg_ch] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_TERM (DEFAULT_TERM)
        ) u_ch (
            .origin_clk (origin_clk),
            .rst        (rst),
            .en         (en[g]),
            .restart    (restart[g]),
            .cfg_we     (cfg_we[g]),
            .cfg_term   (cfg_term),
            .cfg_mode   (cfg_mode),
            .tick       (tick[g]),
            .sq         (sq[g]),
            .pending    (pending[g]),
            .done       (done[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with hand-computed expectations per cycle.
module tb_tick_generator;

    localparam int unsigned N_CH         = 2;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned DEFAULT_TERM = 999;

    logic             origin_clk = 1'b0;
    logic             rst;
    logic [1:0]       en;
    logic [1:0]       restart;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [0:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_term;
    logic             cfg_mode;
    logic [1:0]       tick;
    logic [1:0]       sq;
    logic [1:0]       pending;
    logic [1:0]       done;

    int n_vec = 0;
    int n_err = 0;
    int now   = 0;
    int b, k, m, p, r, s, t;

    always #5 origin_clk = ~origin_clk;

    tick_generator #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_TERM (DEFAULT_TERM)
    ) dut (
        .origin_clk (origin_clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_term   (cfg_term),
        .cfg_mode   (cfg_mode),
        .tick       (tick),
        .sq         (sq),
        .pending    (pending),
        .done       (done)
    );

    // Advance to cycle c (c > now), landing 2 time units after its opening edge.
    task automatic go(input int c);
        repeat (c - now) @(posedge origin_clk);
        now = c;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 2'b00; restart = 2'b00;
        cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_term = '0; cfg_mode = 1'b0;

        // Reset state
        go(2); #1;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_sq", 32'(sq), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        rst = 1'b0; en = 2'b11;
        b = now;

        // Default term 999 on both channels
        go(b + 998); #1; chk("def_pre", 32'(tick), 0);
        go(b + 999); #1; chk("def_tick1", 32'(tick), 2'b11); chk("def_sq0", 32'(sq), 0);
        go(b + 1000); #1; chk("def_post", 32'(tick), 0); chk("def_sq_rise", 32'(sq), 2'b11);
        go(b + 1999); #1; chk("def_tick2", 32'(tick), 2'b11);
        go(b + 2000); #1; chk("def_sq_fall", 32'(sq), 0);

        // Reprogram both channels while idle
        go(now + 1); rst = 1'b1; en = 2'b00;
        go(now + 1); rst = 1'b0;
        k = now + 1;
        go(k); cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_term = 3; cfg_mode = 1'b0; #1;
        chk("idle_ready0", 32'(cfg_ready), 1);
        go(k + 1); cfg_valid = 1'b0; #1;
        chk("idle_pend_set", 32'(pending), 2'b01);
        chk("stall_ready0", 32'(cfg_ready), 0);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_term = 9; #1;
        chk("idle_ready1", 32'(cfg_ready), 1);
        go(k + 2); cfg_valid = 1'b0; #1; chk("idle_pend2", 32'(pending), 2'b10);
        go(k + 3); #1; chk("idle_pend_clr", 32'(pending), 0);

        // Ch0 term 3 with a 5-cycle pause at cnt=2; ch1 term 9 reprogrammed to 2 at cnt=4
        m = k + 4;
        go(m); en = 2'b11; #1; chk("run_t0", 32'(tick), 0);
        go(m + 2); en = 2'b10; #1; chk("run_t2", 32'(tick), 0);
        go(m + 3); #1; chk("pause_hold", 32'(tick), 0);
        go(m + 4); cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_term = 2; cfg_mode = 1'b0; #1;
        chk("run_ready1", 32'(cfg_ready), 1);
        go(m + 5); cfg_valid = 1'b0; #1;
        chk("run_pend", 32'(pending), 2'b10);
        chk("run_stall", 32'(cfg_ready), 0);
        go(m + 7); en = 2'b11; #1; chk("resume_t", 32'(tick), 0);
        go(m + 8); #1; chk("pause_slip", 32'(tick), 2'b01); chk("pend_hold", 32'(pending), 2'b10);
        go(m + 9); #1; chk("old_term_tick", 32'(tick), 2'b10); chk("stall_at_tick", 32'(cfg_ready), 0);
        go(m + 10); #1;
        chk("apply_pend_clr", 32'(pending), 0);
        chk("apply_ready", 32'(cfg_ready), 1);
        chk("sq_run", 32'(sq), 2'b11);
        go(m + 12); #1; chk("new_term_tick", 32'(tick), 2'b11);
        go(m + 13); #1; chk("sq_run2", 32'(sq), 0);
        go(m + 15); #1; chk("ch1_period3", 32'(tick), 2'b10);
        go(m + 16); #1; chk("ch0_period4", 32'(tick), 2'b01);

        // Ch0 one-shot term 5, then restart
        p = m + 17;
        go(p); en = 2'b00; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_term = 5; cfg_mode = 1'b1; #1;
        chk("os_ready", 32'(cfg_ready), 1);
        go(p + 1); cfg_valid = 1'b0; #1; chk("os_pend", 32'(pending), 2'b01);
        go(p + 2); en = 2'b01; #1; chk("os_applied", 32'(pending), 0); chk("os_t0", 32'(tick), 0);
        go(p + 6); #1; chk("os_pre", 32'(tick), 0);
        go(p + 7); #1; chk("os_tick", 32'(tick), 2'b01);
        go(p + 8); #1;
        chk("os_done", 32'(done), 2'b01);
        chk("os_quiet", 32'(tick), 0);
        chk("os_sq", 32'(sq & 2'b01), 0);
        go(p + 12); #1; chk("os_stays", 32'(tick), 0);
        r = p + 13;
        go(r); restart = 2'b01;
        go(r + 1); restart = 2'b00; #1; chk("rs_done_clr", 32'(done), 0);
        go(r + 5); #1; chk("rs_pre", 32'(tick), 0);
        go(r + 6); #1; chk("rs_tick", 32'(tick), 2'b01);
        go(r + 7); #1; chk("rs_done", 32'(done), 2'b01);

        // Restart and config on ch0 in the same cycle
        s = r + 9;
        go(s); restart = 2'b01; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_term = 2; cfg_mode = 1'b0; #1;
        chk("rc_ready", 32'(cfg_ready), 1);
        go(s + 1); restart = 2'b00; cfg_valid = 1'b0; #1;
        chk("rc_pend", 32'(pending), 2'b01);
        chk("rc_done", 32'(done), 0);
        go(s + 3); #1; chk("rc_not_early", 32'(tick), 0);
        go(s + 5); #1; chk("rc_pre", 32'(tick), 0);
        go(s + 6); #1; chk("rc_old_tick", 32'(tick), 2'b01);
        go(s + 7); #1; chk("rc_pend_clr", 32'(pending), 0); chk("rc_no_done", 32'(done), 0);
        go(s + 9); #1; chk("rc_new_tick1", 32'(tick), 2'b01);
        go(s + 12); #1; chk("rc_new_tick2", 32'(tick), 2'b01);

        // Ch1 term 0, then reset mid-run
        t = s + 13;
        go(t); cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_term = 0; cfg_mode = 1'b0;
        go(t + 1); cfg_valid = 1'b0; #1; chk("t0_pend", 32'(pending & 2'b10), 2'b10);
        go(t + 2); en = 2'b11; restart = 2'b10; #1; chk("t0_applied", 32'(pending & 2'b10), 0);
        go(t + 3); restart = 2'b00; #1;
        chk("t0_tick_a", 32'(tick & 2'b10), 2'b10);
        chk("t0_sq_a", 32'(sq & 2'b10), 0);
        go(t + 4); #1;
        chk("t0_tick_b", 32'(tick & 2'b10), 2'b10);
        chk("t0_sq_b", 32'(sq & 2'b10), 2'b10);
        go(t + 5); rst = 1'b1; #1;
        chk("rst_gate_tick", 32'(tick), 0);
        chk("t0_sq_c", 32'(sq & 2'b10), 0);
        go(t + 6); rst = 1'b0; #1;
        chk("mid_rst_sq", 32'(sq), 0);
        chk("mid_rst_pend", 32'(pending), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_tick", 32'(tick), 0);
        go(t + 6 + 998); #1; chk("mid_rst_pre", 32'(tick), 0);
        go(t + 6 + 999); #1; chk("mid_rst_term999", 32'(tick), 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
